// File: rtl/heater_prbs_lane.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : heater_prbs_lane
// Brief    : Power-stress lane. A PRBS word stream goes through a register
//            pipeline and an SRL delay, then is checked against a locally
//            regenerated copy, with a sticky error flag and a mismatch count.
// Revision : 1.0 - initial release
// ============================================================================
module heater_prbs_lane #(
  parameter int          WIDTH = 32,
  parameter int          NPIPE = 32,
  parameter int          NSRL  = 8,
  parameter logic [31:0] SEED  = 32'h1234_5678,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             err_clear,
  input  logic             inj_err,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] err_count
);

  localparam int             C_LAT     = NPIPE + NSRL;
  localparam int             C_OCC_W   = $clog2(C_LAT + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  function automatic logic [WIDTH-1:0] widen(input logic [31:0] s);
    logic [WIDTH-1:0] w;
    for (int i = 0; i < WIDTH; i++) w[i] = s[5'(i % 32)];
    return w;
  endfunction

  logic [31:0]        r_gen_lfsr;
  logic [31:0]        r_chk_lfsr;
  logic [WIDTH-1:0]   w_inj_word;
  logic [WIDTH-1:0]   r_pipe_data [NPIPE];
  logic [WIDTH-1:0]   r_srl_data  [NSRL];
  logic [C_LAT-1:0]   r_vld;
  logic [WIDTH-1:0]   r_chk_data;
  logic               r_chk_vld;
  logic               w_arrive;
  logic               w_mismatch;
  logic [C_OCC_W-1:0] r_occ;
  logic [C_OCC_W-1:0] w_occ_next;
  state_t             r_state;
  state_t             w_state_next;

  // Generator: the word injected this edge is the LFSR value before it advances
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)    r_gen_lfsr <= SEED;
    else if (enable) r_gen_lfsr <= lfsr_next(r_gen_lfsr);
  end

  assign w_inj_word = widen(r_gen_lfsr) ^ {{(WIDTH-1){1'b0}}, inj_err};

  // Data stages carry no reset so the tail maps onto SRL primitives
  always_ff @(posedge clk) begin
    r_pipe_data[0] <= w_inj_word;
    for (int i = 1; i < NPIPE; i++) r_pipe_data[i] <= r_pipe_data[i-1];
    r_srl_data[0] <= r_pipe_data[NPIPE-1];
    for (int i = 1; i < NSRL; i++) r_srl_data[i] <= r_srl_data[i-1];
    r_chk_data <= r_srl_data[NSRL-1];
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_vld     <= '0;
      r_chk_vld <= 1'b0;
    end else begin
      r_vld[0] <= enable;
      for (int i = 1; i < C_LAT; i++) r_vld[i] <= r_vld[i-1];
      r_chk_vld <= r_vld[C_LAT-1];
    end
  end

  assign w_arrive   = r_vld[C_LAT-1];
  assign w_mismatch = r_chk_vld && (r_chk_data != widen(r_chk_lfsr));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)       r_chk_lfsr <= SEED;
    else if (r_chk_vld) r_chk_lfsr <= lfsr_next(r_chk_lfsr);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (err_clear) begin
      error     <= 1'b0;
      err_count <= '0;
    end else if (w_mismatch) begin
      error <= 1'b1;
      if (err_count != C_CNT_MAX) err_count <= err_count + 1'b1;
    end
  end

  // Occupancy covers words between injection and entry into the checker register
  always_comb begin
    w_occ_next = r_occ;
    if (enable && !w_arrive)      w_occ_next = r_occ + C_OCC_W'(1);
    else if (!enable && w_arrive) w_occ_next = r_occ - C_OCC_W'(1);
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (enable) w_state_next = RUN;
      RUN:     if (!enable) w_state_next = (w_occ_next != '0) ? DRAIN : IDLE;
      DRAIN: begin
        if (enable)                 w_state_next = RUN;
        else if (w_occ_next == '0)  w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= IDLE;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_next;
      r_occ   <= w_occ_next;
    end
  end

  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire
